// File: rtl/rgb_pwm_fader.sv
// Fades an on/off RGB color code into active-low per-channel PWM LED drive, one duty step per fade tick.
// Optional GAMMA_EN macro applies square-law correction to each channel's duty before the PWM compare.
module rgb_pwm_fader #(
  parameter int PWM_BITS   = 8,
  parameter int MAX_DUTY   = 255,
  parameter int FADE_TICKS = 12000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] color_i,
  output logic       busy_o,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B
);

  localparam int TICK_W = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] CNT_LAST  = '1;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_TICKS - 1);

  typedef enum logic {IDLE, FADING} state_t;

  state_t              state;
  state_t              state_next;
  logic [2:0]          color_q;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_end;
  logic [PWM_BITS-1:0] duty     [3];
  logic [PWM_BITS-1:0] target   [3];
  logic [PWM_BITS-1:0] duty_eff [3];
  logic [PWM_BITS-1:0] shadow   [3];
  logic [2:0]          led_q;
  logic                mismatch;

  // Moves one count toward the target; never overshoots, so duty stays bounded by the target range.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    if (cur < tgt)
      return cur + PWM_BITS'(1);
    else if (cur > tgt)
      return cur - PWM_BITS'(1);
    else
      return cur;
  endfunction

`ifdef GAMMA_EN
  function automatic logic [PWM_BITS-1:0] gamma_sq(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    return PWM_BITS'(sq >> PWM_BITS);
  endfunction
`endif

  assign tick       = (tick_cnt == TICK_LAST);
  assign period_end = (pwm_cnt == CNT_LAST);

  always_comb begin
    mismatch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      target[k] = color_q[k] ? DUTY_MAX : '0;
`ifdef GAMMA_EN
      duty_eff[k] = gamma_sq(duty[k]);
`else
      duty_eff[k] = duty[k];
`endif
      if (duty[k] != target[k])
        mismatch = 1'b1;
    end
  end

  // Stage: input color register and free-running timebases
  always_ff @(posedge CLK) begin
    if (RST) begin
      color_q  <= '0;
      tick_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      color_q  <= color_i;
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Stage: duty ramp, and shadow latch at the period boundary (takes the pre-step duty on a coincident tick)
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 3; k++) begin
        duty[k]   <= '0;
        shadow[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (tick)
          duty[k] <= step_toward(duty[k], target[k]);
        if (period_end)
          shadow[k] <= duty_eff[k];
      end
    end
  end

  // Stage: registered active-low pin drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q <= '1;
    end else begin
      for (int k = 0; k < 3; k++)
        led_q[k] <= ~(pwm_cnt < shadow[k]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    case (state)
      IDLE: begin
        if (mismatch)
          state_next = FADING;
      end
      FADING: begin
        busy_o = 1'b1;
        if (!mismatch)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign LED_R = led_q[2];
  assign LED_G = led_q[1];
  assign LED_B = led_q[0];

endmodule
